alarm_snooze_ctrl: RTL
======================

// Module: alarm_snooze_ctrl
// PURPOSE
//  Downstream of the alarm/time comparator. Consumes its alarm level and alarm_enable.
//  Drives the buzzer tone and the ringing/snoozing indicators.
//  Handles the snooze button (bounded number of snoozes) and auto-silences after a ring timeout.
// PARAMETERS
//  SNOOZE_SEC        300    seconds of silence per snooze
//  RING_TIMEOUT_SEC  60     seconds of continuous ringing before auto-silence
//  MAX_SNOOZE        3      snoozes allowed per alarm event
//  TONE_DIV          50000  clk cycles per buzzer half-period
// PORTS
//  clk           in   1  system clock
//  reset         in   1  synchronous, active-high reset
//  tick_1hz      in   1  one-clk pulse once per second
//  alarm_enable  in   1  user alarm enable switch (level)
//  alarm         in   1  alarm match level from comparator
//  snooze_btn    in   1  debounced snooze button (level)
//  buzzer        out  1  square-wave tone output
//  ringing       out  1  high in RING state
//  snoozing      out  1  high in SNOOZE state
//  snooze_cnt    out  W  snoozes used this event, W=$clog2(MAX_SNOOZE+1)
// BEHAVIOUR
//  - Clocking: one clock domain. Reset is synchronous and active-high.
//  - Reset state: IDLE. All outputs 0. All counters 0. Edge-detect registers 0.
//  - Edge detection:
//      alarm_rise = alarm & ~alarm_q
//      snz_rise   = snooze_btn & ~snz_q
//  - States: IDLE, RING, SNOOZE, DONE. Outputs are registered and change one cycle after the transition condition.
//  - IDLE -> RING on alarm_rise with alarm_enable=1.
//      ring_sec <= 0, snooze_cnt <= 0, tone divider cleared.
//  - RING, on snz_rise with snooze_cnt < MAX_SNOOZE:
//      -> SNOOZE, snz_sec <= SNOOZE_SEC, snooze_cnt += 1.
//  - RING, on snz_rise with snooze_cnt == MAX_SNOOZE: press is ignored and ringing continues.
//  - RING, on tick_1hz: ring_sec += 1. When ring_sec reaches RING_TIMEOUT_SEC -> DONE.
//  - SNOOZE, on tick_1hz: snz_sec -= 1. On the tick that takes it from 1 to 0 -> RING, ring_sec <= 0.
//  - SNOOZE: snz_rise is ignored.
//  - DONE: silent. Stays here until alarm_enable=0 (comparator re-arms only via disable).
//  - alarm_enable=0 in any state -> IDLE next cycle, counters cleared. This has priority over every other event.
//  - Same-cycle events in RING: snz_rise beats tick_1hz. The tick is not counted.
//  - An alarm level that is already high at reset release does not ring; only a rising edge does.
//  - buzzer:
//      - Toggles every TONE_DIV clk cycles while in RING; otherwise 0.
//      - Divider restarts at 0 on each entry to RING.
//      - First toggle occurs TONE_DIV cycles after entry.
//  - Widths:
//      - ring_sec is $clog2(RING_TIMEOUT_SEC+1) bits and saturates; it never wraps.
//      - snz_sec is $clog2(SNOOZE_SEC+1) bits and never underflows.
// CONFIGURATION
//  - Macro ALARM_BEEP_PATTERN_EN:
//      - Defined: buzzer is additionally gated by a beep_on flag. beep_on is set to 1 on RING entry and toggled on each tick_1hz in RING, giving 1 s on / 1 s off. ringing stays high throughout.
//      - Undefined: continuous tone for the whole time in RING.
// STRUCTURE
//  - Shared package file alarm_pkg.vh holds:
//      - state encoding localparams (ST_IDLE=2'd0, ST_RING=2'd1, ST_SNOOZE=2'd2, ST_DONE=2'd3)
//      - default SNOOZE_SEC, RING_TIMEOUT_SEC, MAX_SNOOZE, TONE_DIV
//  - One sub-module, alarm_tone_gen:
//      - ports: clk, reset, en, tone
//      - TONE_DIV divider; its counter clears while en=0
//  - FSM and second counters live in the top module.
// TESTING
//  Bench parameters: SNOOZE_SEC=3, RING_TIMEOUT_SEC=4, MAX_SNOOZE=2, TONE_DIV=4. tick_1hz pulses every 20 clks.
//  1. enable=1, alarm 0->1
//       -> ringing=1 next cycle; buzzer first toggles 4 clks after entry, then period 8 clks.
//  2. In RING, pulse snooze_btn
//       -> snoozing=1, snooze_cnt=1, buzzer=0; ringing=1 again on the 3rd tick.
//  3. Snooze twice, then press a 3rd time
//       -> snooze_cnt stays 2, state stays RING.
//  4. No press for 4 ticks
//       -> DONE: ringing=0, buzzer=0; stays silent until enable=0, then IDLE.
//  5. enable 1->0 mid-SNOOZE, same cycle as a tick
//       -> IDLE next cycle, snooze_cnt=0, all outputs 0.
//  6. reset=1 while ringing; release with alarm still high
//       -> all outputs 0 and no re-ring until alarm falls and rises again.
//  Run tests 1–6 both with and without ALARM_BEEP_PATTERN_EN. With it, also check buzzer is silent during alternate seconds.

Source files
------------

// File: rtl/alarm_pkg.sv
// alarm_pkg: state encoding and default timing parameters for the alarm snooze controller
package alarm_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RING   = 2'd1;
  localparam logic [1:0] ST_SNOOZE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;
  localparam int DEF_SNOOZE_SEC       = 300;
  localparam int DEF_RING_TIMEOUT_SEC = 60;
  localparam int DEF_MAX_SNOOZE       = 3;
  localparam int DEF_TONE_DIV         = 50000;
endpackage

// File: rtl/alarm_snooze_ctrl_if.sv
// alarm_snooze_ctrl_if: comparator/button inputs and buzzer/indicator outputs of the snooze controller
interface alarm_snooze_ctrl_if import alarm_pkg::*; #(
  parameter int MAX_SNOOZE = DEF_MAX_SNOOZE
);
  localparam int W = $clog2(MAX_SNOOZE + 1);
  logic         tick_1hz;
  logic         alarm_enable;
  logic         alarm;
  logic         snooze_btn;
  logic         buzzer;
  logic         ringing;
  logic         snoozing;
  logic [W-1:0] snooze_cnt;
  modport master (
    output tick_1hz, alarm_enable, alarm, snooze_btn,
    input  buzzer, ringing, snoozing, snooze_cnt
  );
  modport slave (
    input  tick_1hz, alarm_enable, alarm, snooze_btn,
    output buzzer, ringing, snoozing, snooze_cnt
  );
endinterface

// File: rtl/alarm_tone_gen.sv
// alarm_tone_gen: square wave toggling every TONE_DIV cycles while en is high; restarts from 0 whenever en drops
module alarm_tone_gen import alarm_pkg::*; #(
  parameter int TONE_DIV = DEF_TONE_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tone
);
  localparam int DW = $clog2(TONE_DIV + 1);
  logic [DW-1:0] cnt;
  logic          tone_q;
  always_ff @(posedge clk)
    if (reset || !en) begin
      cnt    <= '0;
      tone_q <= 1'b0;
    end else if (cnt == DW'(TONE_DIV - 1)) begin
      cnt    <= '0;
      tone_q <= ~tone_q;
    end else
      cnt <= cnt + DW'(1);
  // gating by en keeps the tone silent on the very cycle the controller leaves RING
  assign tone = tone_q & en;
endmodule

// File: rtl/alarm_snooze_ctrl.sv
// alarm_snooze_ctrl: ring/snooze/auto-silence FSM driving the buzzer from the alarm comparator level.
// Optional ALARM_BEEP_PATTERN_EN: buzzer gated 1 s on / 1 s off while ringing.
module alarm_snooze_ctrl import alarm_pkg::*; #(
  parameter int SNOOZE_SEC       = DEF_SNOOZE_SEC,
  parameter int RING_TIMEOUT_SEC = DEF_RING_TIMEOUT_SEC,
  parameter int MAX_SNOOZE       = DEF_MAX_SNOOZE,
  parameter int TONE_DIV         = DEF_TONE_DIV
) (
  input logic clk,
  input logic reset,
  alarm_snooze_ctrl_if.slave bus
);
  localparam int RW = $clog2(RING_TIMEOUT_SEC + 1);
  localparam int SW = $clog2(SNOOZE_SEC + 1);
  localparam int CW = $clog2(MAX_SNOOZE + 1);
  logic [1:0]    state;
  logic [RW-1:0] ring_sec;
  logic [SW-1:0] snz_sec;
  logic [CW-1:0] snooze_cnt;
  logic          alarm_q, snz_q, live;
  logic          alarm_rise, snz_rise, ringing, tone_en;
  // live masks the first post-reset cycle so an alarm already high at release is not seen as an edge
  assign alarm_rise = live & bus.alarm & ~alarm_q;
  assign snz_rise   = bus.snooze_btn & ~snz_q;
  always_ff @(posedge clk)
    if (reset) begin
      state      <= ST_IDLE;
      ring_sec   <= '0;
      snz_sec    <= '0;
      snooze_cnt <= '0;
      alarm_q    <= 1'b0;
      snz_q      <= 1'b0;
      live       <= 1'b0;
    end else begin
      alarm_q <= bus.alarm;
      snz_q   <= bus.snooze_btn;
      live    <= 1'b1;
      if (!bus.alarm_enable) begin
        state      <= ST_IDLE;
        ring_sec   <= '0;
        snz_sec    <= '0;
        snooze_cnt <= '0;
      end else
        case (state)
          ST_IDLE:
            if (alarm_rise) begin
              state      <= ST_RING;
              ring_sec   <= '0;
              snooze_cnt <= '0;
            end
          ST_RING:
            if (snz_rise) begin
              if (snooze_cnt < CW'(MAX_SNOOZE)) begin
                state      <= ST_SNOOZE;
                snz_sec    <= SW'(SNOOZE_SEC);
                snooze_cnt <= snooze_cnt + CW'(1);
              end
            end else if (bus.tick_1hz) begin
              ring_sec <= (ring_sec == RW'(RING_TIMEOUT_SEC)) ? ring_sec : ring_sec + RW'(1);
              if (ring_sec >= RW'(RING_TIMEOUT_SEC - 1)) state <= ST_DONE;
            end
          ST_SNOOZE:
            if (bus.tick_1hz && snz_sec != '0) begin
              snz_sec <= snz_sec - SW'(1);
              if (snz_sec == SW'(1)) begin
                state    <= ST_RING;
                ring_sec <= '0;
              end
            end
          ST_DONE: ;
          default: state <= ST_IDLE;
        endcase
    end
  assign ringing = (state == ST_RING);
`ifdef ALARM_BEEP_PATTERN_EN
  logic beep_on;
  // held at 1 outside RING so every entry starts with an audible second
  always_ff @(posedge clk)
    if (reset)
      beep_on <= 1'b0;
    else if (!ringing)
      beep_on <= 1'b1;
    else if (bus.tick_1hz && !snz_rise)
      beep_on <= ~beep_on;
  assign tone_en = ringing & beep_on;
`else
  assign tone_en = ringing;
`endif
  alarm_tone_gen #(.TONE_DIV(TONE_DIV)) u_tone (
    .clk   (clk),
    .reset (reset),
    .en    (tone_en),
    .tone  (bus.buzzer)
  );
  assign bus.ringing    = ringing;
  assign bus.snoozing   = (state == ST_SNOOZE);
  assign bus.snooze_cnt = snooze_cnt;
endmodule
